gifplayer_image_details_reader: RTL and testbench
=================================================

Name: gifplayer_image_details_reader

Overview:
- Avalon-MM read master that fetches the 4-word x 16-bit image-details RAM: word0 width, word1 height, word2 frame count, word3 frame delay in ms.
- The RAM is written by the Nios II software after it parses the GIF header.
- On a start pulse, the block reads all four words, checks them, and publishes them atomically as registered outputs for the hardware frame decoder and VGA scaler.
- It is the hardware-side consumer of the details RAM's s2 slave port.

Parameters:
- ADDR_W, 16, width of avm_address in bits (byte address).
- BASE_ADDR, 16'h0000, byte address of word0 of the details RAM.
- NUM_WORDS, 4, number of 16-bit words fetched. Fixed at 4; any other value is a configuration error.
- READ_LATENCY, 1, slave read latency in cycles after command acceptance. Legal range 1..3.
- TIMEOUT_CYCLES, 255, maximum number of cycles waitrequest may stall one read.
- MAX_DIM, 640, largest legal width and largest legal height.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; requests a fetch.
- busy  out  1  high while a fetch is in progress.
- done  out  1  one-cycle pulse at the end of every fetch, including failed fetches.
- details_valid  out  1  high when the published values come from a successful fetch.
- details_err  out  1  sticky error flag; cleared by the next start.
- img_width  out  16  published width.
- img_height  out  16  published height.
- frame_count  out  16  published frame count.
- frame_delay  out  16  published frame delay.
- avm_address  out  ADDR_W  byte address of the current read.
- avm_read  out  1  read request.
- avm_byteenable  out  2  byte enables; constant 2'b11.
- avm_readdata  in  16  read data from the slave.
- avm_waitrequest  in  1  slave stall.

Behaviour:
- Reset (asynchronous):
  - State is IDLE.
  - busy, done, details_valid, details_err and avm_read are 0.
  - avm_address = BASE_ADDR.
  - All published values, shadow registers and counters are 0.
  - Reset asserted mid-fetch aborts immediately; no partial publish.
- States are IDLE, REQ, WAIT_DATA, CHECK, FINISH.
- IDLE:
  - start=1 clears details_err, sets idx=0 and goes to REQ.
  - start while busy is ignored, not queued.
- REQ:
  - avm_read=1 and avm_address = BASE_ADDR + 2*idx, both held stable while waitrequest=1.
  - Acceptance is a clock edge with avm_read=1 and avm_waitrequest=0.
  - On acceptance: avm_read drops the next cycle, the latency counter is loaded with READ_LATENCY, and the state goes to WAIT_DATA.
  - Each stalled cycle increments the stall counter. When it reaches TIMEOUT_CYCLES: avm_read drops, details_err=1, go to FINISH. Published values and details_valid are unchanged.
- WAIT_DATA:
  - The latency counter decrements each cycle.
  - On the edge where it reaches 0, avm_readdata is captured into shadow[idx].
  - If idx=3, go to CHECK; otherwise idx++ and go to REQ.
  - Accepted reads therefore issue at most one every READ_LATENCY+1 cycles.
- CHECK (1 cycle):
  - Fails if width=0, height=0, width>MAX_DIM, height>MAX_DIM, or frame_count=0.
  - Pass: copy all four shadows to the published outputs in the same edge; details_valid=1.
  - Fail: details_err=1, details_valid=0, published outputs unchanged.
- FINISH:
  - done=1 for exactly one cycle, then return to IDLE.
  - busy=1 in every state except IDLE.
- Latency: with no stalls and READ_LATENCY=1, done is asserted 10 cycles after the start edge (4 reads x 2 cycles, plus CHECK, plus FINISH).
- Arithmetic:
  - Address is computed modulo 2^ADDR_W.
  - Stall counter is 8 bits, reset on each acceptance.
  - Comparisons are unsigned 16-bit.
- Values are never published partially; the four outputs always change on the same edge.

Test Plan:
- Preload RAM {320,200,12,100}, waitrequest=0, latency 1, pulse start -> reads at byte addresses 0,2,4,6. done occurs 10 cycles after start. Outputs = 320/200/12/100, details_valid=1, details_err=0.
- Hold waitrequest=1 for 5 cycles on word1 -> address 0x0002 and avm_read stay stable for all 5 cycles. done occurs 5 cycles later than the unstalled run. Values are correct.
- Hold waitrequest=1 permanently on word2 -> details_err=1 after 255 stall cycles, done pulses once, the earlier published values are kept, avm_read=0.
- Preload {700,200,1,50} after a good fetch -> details_err=1, details_valid=0, img_width still shows the previous value (320).
- Pulse start again at cycle 3 of a fetch -> ignored; exactly one done pulse.
- Deassert reset_n during WAIT_DATA of word2 -> all outputs 0 in the same cycle. A fresh start after reset completes normally.

Source files
------------

// File: rtl/gifplayer_image_details_reader.sv
// gifplayer_image_details_reader: Avalon-MM master that fetches the 4-word image-details RAM,
// validates width/height/frame count and publishes all four values atomically.
module gifplayer_image_details_reader #(
    parameter int ADDR_W = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
    parameter int NUM_WORDS = 4,
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_DIM = 640
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              details_valid,
    output logic              details_err,
    output logic [15:0]       img_width,
    output logic [15:0]       img_height,
    output logic [15:0]       frame_count,
    output logic [15:0]       frame_delay,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic [1:0]        avm_byteenable,
    input  logic [15:0]       avm_readdata,
    input  logic              avm_waitrequest
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT_DATA, CHECK, FINISH} state_t;
    state_t state, state_nx;
    logic [1:0] idx;
    logic [1:0] lat;
    logic [7:0] stall;
    logic [15:0] shadow [4];
    logic accept, timeout, last_beat, bad;

    if (NUM_WORDS != 4 || READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_cfg
        $error("gifplayer_image_details_reader: unsupported NUM_WORDS or READ_LATENCY");
    end

    assign accept    = state == REQ && !avm_waitrequest;
    assign timeout   = state == REQ && avm_waitrequest && stall == 8'(TIMEOUT_CYCLES - 1);
    assign last_beat = state == WAIT_DATA && lat == 2'd1;
    assign bad       = shadow[0] == 16'd0 || shadow[1] == 16'd0 || shadow[2] == 16'd0 ||
                       shadow[0] > 16'(MAX_DIM) || shadow[1] > 16'(MAX_DIM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = start ? REQ : IDLE;
            REQ:       state_nx = accept ? WAIT_DATA : timeout ? FINISH : REQ;
            WAIT_DATA: state_nx = !last_beat ? WAIT_DATA : idx == 2'd3 ? CHECK : REQ;
            CHECK:     state_nx = FINISH;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy           = state != IDLE;
        done           = state == FINISH;
        avm_read       = state == REQ;
        avm_address    = BASE_ADDR + ADDR_W'({idx, 1'b0});
        avm_byteenable = 2'b11;
    end

    // Shadows fill one word per read; the published set only moves on a passing CHECK.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx           <= '0;
            lat           <= '0;
            stall         <= '0;
            shadow        <= '{default: '0};
            details_valid <= 1'b0;
            details_err   <= 1'b0;
            img_width     <= '0;
            img_height    <= '0;
            frame_count   <= '0;
            frame_delay   <= '0;
        end else begin
            if (state == IDLE && start) begin
                details_err <= 1'b0;
                idx         <= '0;
                stall       <= '0;
            end
            if (accept) begin
                lat   <= 2'(READ_LATENCY);
                stall <= '0;
            end else if (timeout) begin
                details_err <= 1'b1;
                stall       <= '0;
            end else if (state == REQ) begin
                stall <= stall + 8'd1;
            end
            if (state == WAIT_DATA) lat <= lat - 2'd1;
            if (last_beat) begin
                shadow[idx] <= avm_readdata;
                idx         <= idx + 2'd1;
            end
            if (state == CHECK) begin
                details_valid <= !bad;
                if (bad) details_err <= 1'b1;
                else begin
                    img_width   <= shadow[0];
                    img_height  <= shadow[1];
                    frame_count <= shadow[2];
                    frame_delay <= shadow[3];
                end
            end
        end
    end
endmodule

// File: tb/tb_gifplayer_image_details_reader.sv
// tb_gifplayer_image_details_reader: table-driven and randomized checks of the details reader
// against a stalling Avalon slave and a cycle-count / validation model.
module tb_gifplayer_image_details_reader;
    localparam int RL  = 1;
    localparam int TMO = 255;

    typedef struct {
        logic [3:0][15:0] v;
        int               sidx;
        int               slen;
        bit               ev;
        bit               ee;
        logic [3:0][15:0] e;
        int               elat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, details_valid, details_err;
    logic [15:0] img_width, img_height, frame_count, frame_delay;
    logic [15:0] avm_address;
    logic        avm_read;
    logic [1:0]  avm_byteenable;
    logic [15:0] avm_readdata = '0;
    logic        avm_waitrequest;

    logic [15:0] mem [4];
    int          stall_plan [4];
    int          stall_cnt = 0;
    bit          acc_n = 1'b0, stl_n = 1'b0, prev_stall = 1'b0;
    logic [15:0] addr_n = '0, prev_addr = '0;
    logic [15:0] acc_q [$];
    int          unstable = 0;
    int          checks = 0, errors = 0;
    logic [15:0] m_pub [4];
    bit          m_valid = 1'b0, m_err = 1'b0;
    vec_t        tbl [13];

    always #5 clk = ~clk;

    gifplayer_image_details_reader #(
        .ADDR_W(16), .BASE_ADDR(16'h0000), .NUM_WORDS(4),
        .READ_LATENCY(RL), .TIMEOUT_CYCLES(TMO), .MAX_DIM(640)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .busy(busy), .done(done), .details_valid(details_valid), .details_err(details_err),
        .img_width(img_width), .img_height(img_height),
        .frame_count(frame_count), .frame_delay(frame_delay),
        .avm_address(avm_address), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
    );

    // Slave: stalls each word for stall_plan[word] cycles, returns data one cycle after acceptance.
    assign avm_waitrequest = avm_read && (stall_cnt < stall_plan[avm_address[2:1]]);

    always @(negedge clk) begin
        acc_n  = avm_read && !avm_waitrequest;
        stl_n  = avm_read && avm_waitrequest;
        addr_n = avm_address;
        if (acc_n) acc_q.push_back(avm_address);
        if (stl_n && prev_stall && avm_address != prev_addr) unstable++;
        prev_stall = stl_n;
        prev_addr  = avm_address;
    end

    always @(posedge clk) begin
        stall_cnt    <= stl_n ? stall_cnt + 1 : 0;
        avm_readdata <= acc_n ? mem[addr_n[2:1]] : 16'($urandom);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] w, h, c, d, input int sidx, slen,
                                input bit ev, ee, input logic [15:0] ew, eh, ec, ed, input int elat);
        vec_t r;
        r.v    = {d, c, h, w};
        r.sidx = sidx;
        r.slen = slen;
        r.ev   = ev;
        r.ee   = ee;
        r.e    = {ed, ec, eh, ew};
        r.elat = elat;
        return r;
    endfunction

    task automatic load(input logic [3:0][15:0] v, input int sidx, input int slen);
        for (int i = 0; i < 4; i++) begin
            mem[i]        = v[i];
            stall_plan[i] = 0;
        end
        stall_plan[sidx] = slen;
    endtask

    // Reference: each read costs stalls+1+RL cycles, then CHECK and FINISH; a word stalled
    // TMO times ends the fetch with an error and leaves published values untouched.
    task automatic model_fetch(output int lat, output int nacc);
        lat   = 0;
        nacc  = 0;
        m_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (stall_plan[i] >= TMO) begin
                lat   += TMO + 1;
                m_err = 1'b1;
                return;
            end
            lat += stall_plan[i] + 1 + RL;
            nacc++;
        end
        lat += 2;
        if (mem[0] == 0 || mem[1] == 0 || mem[0] > 640 || mem[1] > 640 || mem[2] == 0) begin
            m_err   = 1'b1;
            m_valid = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) m_pub[i] = mem[i];
            m_valid = 1'b1;
        end
    endtask

    task automatic do_fetch(input string tag, input int restart, input bit ev, ee,
                            input logic [3:0][15:0] e, input int elat, input int nacc);
        int lat, nd, u0;
        u0 = unstable;
        acc_q.delete();
        @(negedge clk);
        start = 1'b1;
        lat = 0;
        nd  = 0;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            start = (n == restart);
            if (done) begin
                nd++;
                if (lat == 0) lat = n;
            end
            if (lat != 0 && n >= lat + 3) break;
        end
        start = 1'b0;
        chk({tag, " latency"}, lat, elat);
        chk({tag, " done_pulses"}, nd, 1);
        chk({tag, " details_valid"}, details_valid, ev);
        chk({tag, " details_err"}, details_err, ee);
        chk({tag, " img_width"}, img_width, e[0]);
        chk({tag, " img_height"}, img_height, e[1]);
        chk({tag, " frame_count"}, frame_count, e[2]);
        chk({tag, " frame_delay"}, frame_delay, e[3]);
        chk({tag, " busy_after"}, busy, 0);
        chk({tag, " avm_read_after"}, avm_read, 0);
        chk({tag, " reads_accepted"}, acc_q.size(), nacc);
        for (int i = 0; i < acc_q.size() && i < nacc; i++) chk({tag, " read_addr"}, acc_q[i], 2 * i);
        chk({tag, " addr_stable"}, unstable - u0, 0);
    endtask

    task automatic model_and_fetch(input string tag, input int restart);
        int elat, nacc;
        model_fetch(elat, nacc);
        do_fetch(tag, restart, m_valid, m_err, {m_pub[3], m_pub[2], m_pub[1], m_pub[0]}, elat, nacc);
    endtask

    initial begin
        int elat, nacc;
        tbl[0]  = mk(320, 200, 12, 100, 0, 0,   1, 0, 320, 200, 12, 100, 10);
        tbl[1]  = mk(320, 200, 12, 100, 1, 5,   1, 0, 320, 200, 12, 100, 15);
        tbl[2]  = mk(111, 222, 3, 4,    2, 999, 1, 1, 320, 200, 12, 100, 260);
        tbl[3]  = mk(700, 200, 1, 50,   0, 0,   0, 1, 320, 200, 12, 100, 10);
        tbl[4]  = mk(640, 640, 1, 0,    0, 0,   1, 0, 640, 640, 1, 0, 10);
        tbl[5]  = mk(641, 10, 1, 1,     0, 0,   0, 1, 640, 640, 1, 0, 10);
        tbl[6]  = mk(10, 641, 1, 1,     0, 0,   0, 1, 640, 640, 1, 0, 10);
        tbl[7]  = mk(0, 5, 1, 1,        0, 0,   0, 1, 640, 640, 1, 0, 10);
        tbl[8]  = mk(5, 0, 1, 1,        0, 0,   0, 1, 640, 640, 1, 0, 10);
        tbl[9]  = mk(5, 5, 0, 1,        0, 0,   0, 1, 640, 640, 1, 0, 10);
        tbl[10] = mk(1, 1, 1, 65535,    0, 254, 1, 0, 1, 1, 1, 65535, 264);
        tbl[11] = mk(9, 9, 9, 9,        3, 255, 1, 1, 1, 1, 1, 65535, 262);
        tbl[12] = mk(9, 9, 9, 9,        0, 255, 1, 1, 1, 1, 1, 65535, 256);
        for (int i = 0; i < 4; i++) begin
            mem[i]        = '0;
            stall_plan[i] = 0;
            m_pub[i]      = '0;
        end

        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset details_valid", details_valid, 0);
        chk("reset details_err", details_err, 0);
        chk("reset img_width", img_width, 0);
        chk("reset img_height", img_height, 0);
        chk("reset frame_count", frame_count, 0);
        chk("reset frame_delay", frame_delay, 0);
        chk("reset avm_read", avm_read, 0);
        chk("reset avm_address", avm_address, 0);
        chk("reset avm_byteenable", avm_byteenable, 3);
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            load(tbl[i].v, tbl[i].sidx, tbl[i].slen);
            model_fetch(elat, nacc);
            do_fetch($sformatf("vec%0d", i), 0, tbl[i].ev, tbl[i].ee, tbl[i].e, tbl[i].elat, nacc);
        end

        // A second start during the fetch must be dropped, not queued.
        load({16'd100, 16'd12, 16'd200, 16'd320}, 0, 0);
        model_and_fetch("restart", 3);

        // Reset while word2 is in WAIT_DATA clears everything immediately.
        load({16'd77, 16'd5, 16'd480, 16'd600}, 0, 0);
        acc_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (acc_q.size() == 3 && !avm_read) break;
        end
        chk("rst_mid reached_word2", acc_q.size(), 3);
        chk("rst_mid busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid busy", busy, 0);
        chk("rst_mid done", done, 0);
        chk("rst_mid details_valid", details_valid, 0);
        chk("rst_mid details_err", details_err, 0);
        chk("rst_mid img_width", img_width, 0);
        chk("rst_mid img_height", img_height, 0);
        chk("rst_mid frame_count", frame_count, 0);
        chk("rst_mid frame_delay", frame_delay, 0);
        chk("rst_mid avm_read", avm_read, 0);
        chk("rst_mid avm_address", avm_address, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) m_pub[i] = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        model_and_fetch("post_reset", 0);

        for (int t = 0; t < 40; t++) begin
            logic [3:0][15:0] v;
            v[0] = 16'($urandom_range(0, 700));
            v[1] = 16'($urandom_range(0, 700));
            v[2] = 16'($urandom_range(0, 4));
            v[3] = 16'($urandom);
            load(v, 0, 0);
            for (int i = 0; i < 4; i++)
                stall_plan[i] = ($urandom_range(0, 19) == 0) ? ($urandom_range(0, 1) ? 255 : 254)
                                                             : int'($urandom_range(0, 3));
            model_and_fetch($sformatf("rand%0d", t), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
